// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: datapath width, register zero and writeback source select.
package rv32_pkg;
    localparam int XLEN = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2,
        WB_MUL  = 2'd3
    } wb_sel_e;
endpackage

// File: rtl/wb_hold_buffer.sv
// One-entry holding buffer for divider results: handshake, younger-wins kill,
// bypass detection and starvation tracking.
module wb_hold_buffer
    import rv32_pkg::*;
#(
    parameter int W            = rv32_pkg::XLEN,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         p_valid,
    input  logic [4:0]   p_rd,
    input  logic         div_valid,
    input  logic [4:0]   div_rd,
    input  logic [W-1:0] div_result,
    output logic         div_ready,
    output logic         bypass,
    output logic         h_valid,
    output logic [4:0]   h_rd,
    output logic [W-1:0] h_data,
    output logic         stall_req
);
    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic [2:0]   h_age;
    logic         h_valid_n;
    logic [4:0]   h_rd_n;
    logic [W-1:0] h_data_n;
    logic [2:0]   h_age_n;
    logic         hs, drain, kill;

    assign div_ready = !h_valid;
    assign hs        = div_valid && div_ready;
    // H only drains when the pipeline leaves the write port free.
    assign drain     = h_valid && !p_valid;
    assign kill      = h_valid && p_valid && (p_rd == h_rd);
    assign bypass    = hs && !p_valid && (div_rd != REG_ZERO);

    always_comb begin
        h_valid_n = h_valid;
        h_rd_n    = h_rd;
        h_data_n  = h_data;
        h_age_n   = h_age;
        if (hs && p_valid && (div_rd != REG_ZERO)) begin
            h_valid_n = 1'b1;
            h_rd_n    = div_rd;
            h_data_n  = div_result;
            h_age_n   = 3'd0;
        end else if (drain || kill) begin
            h_valid_n = 1'b0;
            h_age_n   = 3'd0;
        end else if (h_valid && h_age != 3'd7) begin
            h_age_n = h_age + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_valid   <= 1'b0;
            h_rd      <= REG_ZERO;
            h_data    <= '0;
            h_age     <= 3'd0;
            stall_req <= 1'b0;
        end else begin
            h_valid   <= h_valid_n;
            h_rd      <= h_rd_n;
            h_data    <= h_data_n;
            h_age     <= h_age_n;
            // Stays high past the limit until the entry finally drains.
            stall_req <= h_valid_n && (h_age_n >= LIMIT);
        end
    end
endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: selects the writeback value, arbitrates pipeline vs. divider
// results and drives the registered register-file write port.
module writeback_stage
    import rv32_pkg::*;
#(
    parameter int XLEN         = rv32_pkg::XLEN,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid,
    input  logic            mem_regwrite,
    input  logic [4:0]      mem_rd,
    input  logic [1:0]      mem_wb_sel,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic [XLEN-1:0] mem_load_data,
    input  logic [XLEN-1:0] mem_pc_plus4,
    input  logic [XLEN-1:0] mem_mul_result,
    input  logic            div_valid,
    input  logic [4:0]      div_rd,
    input  logic [XLEN-1:0] div_result,
    output logic            div_ready,
    output logic            stall_req,
    output logic [4:0]      reg_write,
    output logic [XLEN-1:0] write_data,
    output logic            writeenable,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data
);
    logic            p_valid, bypass, h_valid;
    logic [4:0]      h_rd;
    logic [XLEN-1:0] h_data, p_data;
    logic            we_n;
    logic [4:0]      rd_n;
    logic [XLEN-1:0] data_n;

    assign p_valid = mem_valid && mem_regwrite && (mem_rd != REG_ZERO);

    always_comb begin
        case (wb_sel_e'(mem_wb_sel))
            WB_LOAD: p_data = mem_load_data;
            WB_PC4:  p_data = mem_pc_plus4;
            WB_MUL:  p_data = mem_mul_result;
            default: p_data = mem_alu_result;
        endcase
    end

    wb_hold_buffer #(.W(XLEN), .STARVE_LIMIT(STARVE_LIMIT)) u_hold (
        .clk        (clk),
        .rst        (rst),
        .p_valid    (p_valid),
        .p_rd       (mem_rd),
        .div_valid  (div_valid),
        .div_rd     (div_rd),
        .div_result (div_result),
        .div_ready  (div_ready),
        .bypass     (bypass),
        .h_valid    (h_valid),
        .h_rd       (h_rd),
        .h_data     (h_data),
        .stall_req  (stall_req)
    );

    // Pipeline first, then the held result, then a bypassed divider result.
    always_comb begin
        we_n   = 1'b0;
        rd_n   = REG_ZERO;
        data_n = '0;
        if (p_valid) begin
            we_n = 1'b1; rd_n = mem_rd; data_n = p_data;
        end else if (h_valid) begin
            we_n = 1'b1; rd_n = h_rd; data_n = h_data;
        end else if (bypass) begin
            we_n = 1'b1; rd_n = div_rd; data_n = div_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            writeenable <= 1'b0;
            reg_write   <= REG_ZERO;
            write_data  <= '0;
        end else begin
            writeenable <= we_n;
            reg_write   <= rd_n;
            write_data  <= data_n;
        end
    end

    assign fwd_valid = writeenable;
    assign fwd_rd    = reg_write;
    assign fwd_data  = write_data;
endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: vector table for the select/suppress paths,
// hand-written sequences for divider collision, kill, bypass, starvation and reset.
module tb_writeback_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_regwrite;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wb_sel;
    logic [31:0] mem_alu_result, mem_load_data, mem_pc_plus4, mem_mul_result;
    logic        div_valid;
    logic [4:0]  div_rd;
    logic [31:0] div_result;
    logic        div_ready, stall_req, writeenable, fwd_valid;
    logic [4:0]  reg_write, fwd_rd;
    logic [31:0] write_data, fwd_data;

    int tests = 0;
    int fails = 0;
    logic [31:0] rf [32];

    always #5 clk = ~clk;

    writeback_stage #(.XLEN(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
        .mem_wb_sel(mem_wb_sel), .mem_alu_result(mem_alu_result),
        .mem_load_data(mem_load_data), .mem_pc_plus4(mem_pc_plus4),
        .mem_mul_result(mem_mul_result),
        .div_valid(div_valid), .div_rd(div_rd), .div_result(div_result),
        .div_ready(div_ready), .stall_req(stall_req),
        .reg_write(reg_write), .write_data(write_data), .writeenable(writeenable),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    // Simple register-file model committing at the edge after the write is presented.
    always @(posedge clk) begin
        if (!rst && writeenable) rf[reg_write] <= write_data;
    end

    typedef struct {
        logic        valid, regwrite;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [31:0] alu, load, pc4, mul;
        logic        exp_we;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic v, input logic rw, input logic [4:0] rd,
                        input logic [1:0] sel, input logic [31:0] val);
        mem_valid = v; mem_regwrite = rw; mem_rd = rd; mem_wb_sel = sel;
        mem_alu_result = val; mem_load_data = val; mem_pc_plus4 = val; mem_mul_result = val;
    endtask

    task automatic div(input logic v, input logic [4:0] rd, input logic [31:0] val);
        div_valid = v; div_rd = rd; div_result = val;
    endtask

    task automatic check_wr(input string name, input logic we, input logic [4:0] rd,
                            input logic [31:0] data);
        check({name, ".we"}, 32'(writeenable), 32'(we));
        check({name, ".rd"}, 32'(reg_write), 32'(rd));
        check({name, ".data"}, write_data, data);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        vecs[0] = '{1, 1, 5'd5,  2'd0, 32'hDEADBEEF, 32'h1, 32'h2, 32'h3, 1, 5'd5,  32'hDEADBEEF};
        vecs[1] = '{1, 1, 5'd6,  2'd1, 32'h1, 32'h00001234, 32'h2, 32'h3, 1, 5'd6,  32'h00001234};
        vecs[2] = '{1, 1, 5'd1,  2'd2, 32'h1, 32'h2, 32'h00000104, 32'h3, 1, 5'd1,  32'h00000104};
        vecs[3] = '{1, 1, 5'd31, 2'd3, 32'h1, 32'h2, 32'h3, 32'hCAFEF00D, 1, 5'd31, 32'hCAFEF00D};
        vecs[4] = '{1, 1, 5'd0,  2'd0, 32'h99, 32'h2, 32'h3, 32'h4, 0, 5'd0, 32'h0};
        vecs[5] = '{1, 0, 5'd7,  2'd0, 32'h99, 32'h2, 32'h3, 32'h4, 0, 5'd0, 32'h0};
        vecs[6] = '{0, 1, 5'd8,  2'd0, 32'h99, 32'h2, 32'h3, 32'h4, 0, 5'd0, 32'h0};

        rst = 1'b1;
        pipe(0, 0, 5'd0, 2'd0, 32'h0);
        div(0, 5'd0, 32'h0);
        step(); step();
        check_wr("reset", 1'b0, 5'd0, 32'h0);
        check("reset.fwd_valid", 32'(fwd_valid), 32'd0);
        check("reset.fwd_rd", 32'(fwd_rd), 32'd0);
        check("reset.fwd_data", fwd_data, 32'h0);
        check("reset.stall_req", 32'(stall_req), 32'd0);
        check("reset.div_ready", 32'(div_ready), 32'd1);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            mem_valid = vecs[i].valid; mem_regwrite = vecs[i].regwrite;
            mem_rd = vecs[i].rd; mem_wb_sel = vecs[i].sel;
            mem_alu_result = vecs[i].alu; mem_load_data = vecs[i].load;
            mem_pc_plus4 = vecs[i].pc4; mem_mul_result = vecs[i].mul;
            step();
            check_wr($sformatf("vec%0d", i), vecs[i].exp_we, vecs[i].exp_rd, vecs[i].exp_data);
            check($sformatf("vec%0d.fwd_data", i), fwd_data, vecs[i].exp_data);
        end
        check("rf.x5", rf[5], 32'hDEADBEEF);
        check("rf.x31", rf[31], 32'hCAFEF00D);
        check("rf.x0", rf[0], 32'h0);

        // Collision: pipeline wins, divider result parks in H until a bubble.
        pipe(1, 1, 5'd3, 2'd0, 32'h11);
        div(1, 5'd7, 32'h22);
        check("coll.ready_before", 32'(div_ready), 32'd1);
        step();
        div(0, 5'd0, 32'h0);
        check_wr("coll.p", 1'b1, 5'd3, 32'h11);
        check("coll.ready_held", 32'(div_ready), 32'd0);
        pipe(1, 1, 5'd4, 2'd0, 32'h55);
        step();
        check_wr("coll.p2", 1'b1, 5'd4, 32'h55);
        check("coll.ready_held2", 32'(div_ready), 32'd0);
        pipe(0, 0, 5'd0, 2'd0, 32'h0);
        step();
        check_wr("coll.drain", 1'b1, 5'd7, 32'h22);
        check("coll.ready_after", 32'(div_ready), 32'd1);

        // Kill: younger pipeline write to the same rd discards H.
        pipe(1, 1, 5'd2, 2'd0, 32'h66);
        div(1, 5'd9, 32'h33);
        step();
        div(0, 5'd0, 32'h0);
        pipe(1, 1, 5'd9, 2'd0, 32'h44);
        step();
        check_wr("kill.p", 1'b1, 5'd9, 32'h44);
        check("kill.ready", 32'(div_ready), 32'd1);
        pipe(0, 0, 5'd0, 2'd0, 32'h0);
        step();
        check("kill.no_write", 32'(writeenable), 32'd0);

        // Bypass on a bubble, and an x0 divider result that must vanish.
        div(1, 5'd12, 32'h77);
        step();
        div(0, 5'd0, 32'h0);
        check_wr("bypass", 1'b1, 5'd12, 32'h77);
        check("bypass.ready", 32'(div_ready), 32'd1);
        pipe(1, 1, 5'd2, 2'd0, 32'h5);
        div(1, 5'd0, 32'h88);
        step();
        div(0, 5'd0, 32'h0);
        check("divx0.ready", 32'(div_ready), 32'd1);

        // Starvation: back-to-back pipeline writes hold off H until stall_req.
        pipe(1, 1, 5'd2, 2'd0, 32'h1);
        div(1, 5'd10, 32'hAA);
        step();
        div(0, 5'd0, 32'h0);
        pipe(1, 1, 5'd11, 2'd0, 32'h2);
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("starve.stall%0d", i), 32'(stall_req), (i == 4) ? 32'd1 : 32'd0);
        end
        pipe(0, 0, 5'd0, 2'd0, 32'h0);
        step();
        check_wr("starve.drain", 1'b1, 5'd10, 32'hAA);
        check("starve.stall_clear", 32'(stall_req), 32'd0);

        // Reset mid-operation with H valid and a pending pipeline write.
        pipe(1, 1, 5'd2, 2'd0, 32'h3);
        div(1, 5'd13, 32'hBB);
        step();
        div(0, 5'd0, 32'h0);
        pipe(1, 1, 5'd14, 2'd0, 32'hCC);
        rst = 1'b1;
        step();
        check_wr("rstmid", 1'b0, 5'd0, 32'h0);
        check("rstmid.ready", 32'(div_ready), 32'd1);
        rst = 1'b0;
        pipe(0, 0, 5'd0, 2'd0, 32'h0);
        step();
        check("rstmid.no_drain", 32'(writeenable), 32'd0);
        check("rf.x13", rf[13], 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage of the RV32IM core and the write-side master of `register_file`. It registers MEM-stage results, selects the writeback value, and merges results from the multi-cycle M-extension divider through a one-entry holding buffer. It then drives `reg_write` / `write_data` / `writeenable` into the register file, one write per cycle at most.

## Interface
- `XLEN`, 32, datapath width
- `STARVE_LIMIT`, 4, cycles a held divider result may wait before the block forces a pipeline stall
- `clk` in 1: single clock, all state updates on rising edge
- `rst` in 1: synchronous, active-high reset
- `mem_valid` in 1: MEM stage holds a valid instruction this cycle
- `mem_regwrite` in 1: instruction writes a register
- `mem_rd` in 5: destination register
- `mem_wb_sel` in 2: writeback source select. 0 = ALU, 1 = load, 2 = PC+4, 3 = MUL
- `mem_alu_result`, `mem_load_data`, `mem_pc_plus4`, `mem_mul_result` in XLEN: candidate values
- `div_valid` in 1: divider offers a result
- `div_rd` in 5: divider destination
- `div_result` in XLEN: divider quotient/remainder
- `div_ready` out 1: holding buffer empty; the divider transfer completes when `div_valid && div_ready`
- `stall_req` out 1: freeze IF–MEM for this cycle
- `reg_write` out 5, `write_data` out XLEN, `writeenable` out 1: to `register_file`
- `fwd_valid` out 1, `fwd_rd` out 5, `fwd_data` out XLEN: forwarding tap, identical to the write outputs

## Operation
**Pipeline write (P).** A pipeline write is present when `mem_valid && mem_regwrite && mem_rd != 0`. The value is selected by `mem_wb_sel`.

**Holding buffer H.** H is one entry: `h_valid`, `h_rd`, `h_data`, and a starvation counter `h_age` (3 bits, saturating).
- H is loaded on the `div_valid && div_ready` handshake.
- A `div_rd == 0` transfer is accepted but discarded; H stays empty.

**Arbitration, evaluated each cycle.**
- If P is present, P is written.
- Else if `h_valid`, H is written and cleared.
- Else no write; `writeenable` = 0.

**Bypass.** A divider result arriving while H is empty and P is absent is written directly that cycle and is not buffered.

**Younger-wins kill.** If P writes the same rd as a valid H (`mem_rd == h_rd`), H is discarded without writing. The pipeline instruction is younger.

**Starvation.** `h_age` increments each cycle H is valid and not drained. When `h_age == STARVE_LIMIT`, `stall_req` = 1. The MEM stage then presents a bubble (`mem_valid` = 0), so H drains the next write cycle. `h_age` clears on drain or kill.

**Register x0.** x0 is never written: `writeenable` is never asserted with `reg_write` = 0.

## Timing
- **Latency.** Inputs are sampled on edge N. `writeenable`, `reg_write`, and `write_data` are registered and valid from N until N+1. `register_file` commits at edge N+1.
- **Reset values.** `writeenable` = 0, `reg_write` = 0, `write_data` = 0, `fwd_*` = 0, `stall_req` = 0, `div_ready` = 1, `h_valid` = 0, `h_age` = 0.
- **`div_ready`.** It is combinational from `!h_valid`. It may be asserted in the same cycle H drains only if the drain has already registered (no same-cycle refill).
- **`stall_req`.** It is registered from `h_age` and deasserts the cycle after H drains.
- **Reset mid-operation.** Reset discards H and any in-flight write; no write is issued in the reset cycle.
- **Simultaneous P + div handshake with H empty.** P is written and the divider result loads into H.

## Structure
- **Shared package `rv32_pkg`.**
  - `wb_sel_e` enum: `WB_ALU`, `WB_LOAD`, `WB_PC4`, `WB_MUL`
  - `XLEN`
  - `REG_ZERO` = 5'd0
- **One sub-module, `wb_hold_buffer`.** It holds H, the handshake, the kill compare, and `h_age`/starvation. The writeback mux and output registers stay in `writeback_stage`.

## Test plan
- **Reset.** `rst` = 1 for 2 cycles → all outputs 0, `div_ready` = 1. Release, then ALU write rd = 5, data 0xDEADBEEF → `writeenable` = 1, `reg_write` = 5, `write_data` = 0xDEADBEEF one cycle later; register file `read1` = 5 returns 0xDEADBEEF.
- **x0 suppression.** `mem_rd` = 0 with `mem_regwrite` = 1, sel = ALU → `writeenable` stays 0.
- **Collision.** Pipeline write rd = 3, data 0x11, in the same cycle as divider rd = 7, data 0x22 → cycle 1 writes x3 = 0x11. `div_ready` = 0 until the next bubble, then x7 = 0x22 is written.
- **Kill.** H holds rd = 9, data 0x33; pipeline writes rd = 9, data 0x44 → only x9 = 0x44 is written; H is cleared and `div_ready` returns to 1.
- **Starvation.** H valid with back-to-back pipeline writes → `stall_req` = 1 after 4 cycles. With a bubble applied, H drains on the next cycle and `stall_req` = 0 one cycle after.
- **Reset mid-operation.** Assert `rst` with H valid and a pending write → no write issued, `h_valid` = 0, `div_ready` = 1.
